// File: rtl/formal_checker_pkg.sv
// Shared types and default sizes for the formal output checker.
package formal_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int DEF_NUM_OUTPUTS   = 5;
  localparam int DEF_WARMUP_CYCLES = 1;
  localparam int DEF_CHECK_CYCLES  = 10;
  localparam int DEF_ERR_CNT_W     = 16;
  localparam int DEF_CYC_W         = 16;

endpackage

// File: rtl/formal_checker_popcount.sv
// Combinational population count of a NUM_OUTPUTS-wide vector.
module formal_checker_popcount #(
  parameter int NUM_OUTPUTS = 5,
  parameter int CNT_W       = $clog2(NUM_OUTPUTS + 1)
) (
  input  logic [NUM_OUTPUTS-1:0] vec_i,
  output logic [CNT_W-1:0]       cnt_o
);

  // Ripple sum of set bits; NUM_OUTPUTS is small so a plain adder chain is fine.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) cnt_o = cnt_o + CNT_W'(vec_i[i]);
  end

endmodule

// File: rtl/formal_output_checker.sv
// Scoreboard stage: compares fabric outputs against a reference benchmark over
// a fixed window, counts rising mismatch edges and reports a pass/fail verdict.
// Optional first-error capture is enabled by defining FORMAL_CHECKER_FIRST_ERR_EN.
module formal_output_checker
  import formal_checker_pkg::*;
#(
  parameter int NUM_OUTPUTS   = DEF_NUM_OUTPUTS,
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int CHECK_CYCLES  = DEF_CHECK_CYCLES,
  parameter int ERR_CNT_W     = DEF_ERR_CNT_W,
  parameter int CYC_W         = DEF_CYC_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_OUTPUTS-1:0] fpga_out,
  input  logic [NUM_OUTPUTS-1:0] bench_out,
  input  logic [NUM_OUTPUTS-1:0] bench_unknown,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [NUM_OUTPUTS-1:0] flag,
  output logic [ERR_CNT_W-1:0]   err_count,
  output logic [CYC_W-1:0]       first_err_cycle,
  output logic [NUM_OUTPUTS-1:0] first_err_vec
);

  localparam int PCW = $clog2(NUM_OUTPUTS + 1);
  // Sum width wide enough that err + popcount never overflows before the clamp.
  localparam int SW  = ((ERR_CNT_W > PCW) ? ERR_CNT_W : PCW) + 1;
  localparam logic [CYC_W-1:0] WARM_LAST  = CYC_W'(WARMUP_CYCLES - 1);
  localparam logic [CYC_W-1:0] CHECK_LAST = CYC_W'(WARMUP_CYCLES + CHECK_CYCLES - 1);
  localparam logic [SW-1:0]    ERR_MAX    = SW'({ERR_CNT_W{1'b1}});

  state_e                 state_q;
  logic [CYC_W-1:0]       cyc_q;
  logic [NUM_OUTPUTS-1:0] flag_q;
  logic [ERR_CNT_W-1:0]   err_q, err_d;
  logic                   busy_q, done_q, pass_q;

  logic [NUM_OUTPUTS-1:0] mism, new_bits;
  logic [PCW-1:0]         pc;
  logic [SW-1:0]          err_sum;

  // Unknown reference bits never count; only bits that newly start mismatching are events.
  assign mism     = (fpga_out ^ bench_out) & ~bench_unknown;
  assign new_bits = mism & ~flag_q;

  formal_checker_popcount #(.NUM_OUTPUTS(NUM_OUTPUTS), .CNT_W(PCW)) u_pop (
    .vec_i (new_bits),
    .cnt_o (pc)
  );

  // Saturating accumulate of this cycle's rising-edge count.
  always_comb begin
    err_sum = SW'(err_q) + SW'(pc);
    err_d   = (err_sum > ERR_MAX) ? {ERR_CNT_W{1'b1}} : err_sum[ERR_CNT_W-1:0];
  end

  // Run-control FSM with its counters and registered status outputs; start overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      flag_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else if (start) begin
      state_q <= ST_WARMUP;
      cyc_q   <= '0;
      flag_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_WARMUP: begin
          cyc_q <= cyc_q + 1'b1;
          if (cyc_q == WARM_LAST) state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          cyc_q  <= cyc_q + 1'b1;
          flag_q <= mism;
          err_q  <= err_d;
          if (cyc_q == CHECK_LAST) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end
        end
        ST_IDLE: ;
        ST_DONE: ;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign flag      = flag_q;
  assign err_count = err_q;

`ifdef FORMAL_CHECKER_FIRST_ERR_EN
  logic [CYC_W-1:0]       fec_q;
  logic [NUM_OUTPUTS-1:0] fev_q;

  // Latch window index and rising bits on the first event of the run only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fec_q <= '0;
      fev_q <= '0;
    end else if (start) begin
      fec_q <= '0;
      fev_q <= '0;
    end else if (state_q == ST_CHECK && err_q == '0 && pc != '0) begin
      fec_q <= cyc_q - CYC_W'(WARMUP_CYCLES);
      fev_q <= new_bits;
    end
  end

  assign first_err_cycle = fec_q;
  assign first_err_vec   = fev_q;
`else
  assign first_err_cycle = '0;
  assign first_err_vec   = '0;
`endif

endmodule

// File: doc/formal_output_checker.md
Name: formal_output_checker

Overview:
- Synthesizable scoreboard stage directly downstream of a formal-verification top and its reference benchmark.
- Consumes the FPGA-fabric output vector and the benchmark output vector each cycle, flags per-bit mismatches, and counts mismatch events.
- Produces a pass/fail verdict after a fixed check window.
- Used in on-chip and emulation runs of the random formal benches (e.g. adder_4: 5 outputs) where $display checking is unavailable.

Parameters:
- NUM_OUTPUTS, 5, number of compared output bits.
- WARMUP_CYCLES, 1, cycles skipped after start (initialisation cycle), >=1.
- CHECK_CYCLES, 10, number of compared cycles in the window, >=1.
- ERR_CNT_W, 16, error counter width.
- CYC_W, 16, cycle-index width; must hold WARMUP_CYCLES+CHECK_CYCLES.

Ports:
- clk  input  1  Single clock, rising-edge active; the design's only clock.
- rst  input  1  Reset, asynchronous, active-high.
- start  input  1  Single-cycle pulse; clears results and begins a run.
- fpga_out  input  NUM_OUTPUTS  Fabric (gfpga) outputs.
- bench_out  input  NUM_OUTPUTS  Reference benchmark outputs.
- bench_unknown  input  NUM_OUTPUTS  Per-bit "benchmark value is X/don't-care"; masked from comparison.
- busy  output  1  High in WARMUP or CHECK.
- done  output  1  High in DONE.
- pass  output  1  Valid when done; 1 iff err_count==0.
- flag  output  NUM_OUTPUTS  Registered per-bit mismatch of the previous compared cycle.
- err_count  output  ERR_CNT_W  Count of mismatch events; saturating.
- first_err_cycle  output  CYC_W  Check-window index of the first mismatch event.
- first_err_vec  output  NUM_OUTPUTS  flag bits rising at the first mismatch event.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal cycle counter 0.
- FSM states: IDLE, WARMUP, CHECK, DONE.
  - IDLE -> WARMUP on start.
  - WARMUP: count WARMUP_CYCLES cycles, no comparison, flag held 0, then go to CHECK.
  - CHECK: compare for exactly CHECK_CYCLES cycles, then go to DONE.
  - DONE holds all results until the next start.
- start in any state (including mid-WARMUP or mid-CHECK): clear flag, err_count, first_err_*, and the cycle counter; enter WARMUP next cycle. A start in the same cycle as the final CHECK compare wins; that compare is discarded.
- Comparison, in CHECK only: mism = (fpga_out ^ bench_out) & ~bench_unknown. flag <= mism, registered at 1-cycle latency.
- Error events are rising edges of flag, not mismatching cycles:
  - new = mism & ~flag; err_count += popcount(new).
  - Several bits rising in one cycle add their full popcount.
  - A bit that stays mismatched across consecutive cycles counts once.
- The first CHECK cycle compares against flag==0, so any mismatch there counts.
- err_count saturates at 2^ERR_CNT_W-1 and never wraps.
- pass = done && err_count==0; pass is 0 outside DONE.
- On leaving CHECK, flag keeps its last value through DONE.
- rst asserted mid-run: immediate asynchronous return to reset values and IDLE; results are not retained.

Optional Feature:
- Macro: FORMAL_CHECKER_FIRST_ERR_EN.
- Defined: on the first cycle err_count goes from 0 to nonzero, capture first_err_cycle = CHECK-window index (0-based) and first_err_vec = new. Hold both until start or rst; later events do not update them.
- Undefined: no capture registers exist; first_err_cycle and first_err_vec are tied to 0. All other behaviour is identical.

Decomposition:
- Package formal_checker_pkg: state typedef (IDLE/WARMUP/CHECK/DONE encoding) and default width constants.
- One sub-module, formal_checker_popcount: combinational, parameterised by NUM_OUTPUTS, returns popcount of new with width $clog2(NUM_OUTPUTS+1).
- The FSM, counters and saturation logic stay in the top.

Test Plan:
- Matching inputs: fpga_out==bench_out for the whole window, start at cycle 0 -> done after 1+10 cycles, pass=1, err_count=0, flag=0 throughout.
- Persistent single-bit error: bit 2 mismatched in window cycles 3..6 -> err_count=1, flag[2] high for 4 cycles, first_err_cycle=3, first_err_vec=5'b00100 (macro on), pass=0.
- Multi-bit rise and X-mask: bits 0,4 mismatch at cycle 0, bit 1 mismatched with bench_unknown[1]=1 -> err_count=2, flag[1] stays 0.
- Toggling error: bit 0 mismatched on alternate window cycles (5 rises) -> err_count=5. With ERR_CNT_W=2 -> err_count=3 (saturated).
- Restart and reset mid-run: start at window cycle 4 after 2 errors -> counters clear, new full window runs. rst at window cycle 2 -> all outputs 0 and IDLE immediately, no clock needed.
- Macro off: rerun the persistent single-bit error case -> first_err_cycle=0 and first_err_vec=0; err_count/pass unchanged.
